// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory-backed responder with programmable wait states and
// two-cycle ERROR responses for out-of-range, oversized or misaligned accesses.
module ahb_mem_slave #(
  parameter int unsigned AHB_DATA_WIDTH    = 64,
  parameter int unsigned AHB_ADDRESS_WIDTH = 32,
  parameter int unsigned MEM_DEPTH         = 256,
  parameter int unsigned WAIT_STATES       = 1
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic                         HSEL,
  input  logic [AHB_ADDRESS_WIDTH-1:0] HADDR,
  input  logic [1:0]                   HTRANS,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  logic [2:0]                   HBURST,
  input  logic [AHB_DATA_WIDTH-1:0]    HWDATA,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [AHB_DATA_WIDTH-1:0]    HRDATA
);

  localparam int unsigned DW    = AHB_DATA_WIDTH;
  localparam int unsigned AW    = AHB_ADDRESS_WIDTH;
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned BSH   = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BSH-1:0]     lane_q, lane_d;
  logic [2:0]         size_q, size_d;
  logic               write_q, write_d;
  logic               hready_q, hready_d;
  logic               hresp_q, hresp_d;
  logic [DW-1:0]      rdata_q, rdata_d;

  logic [DW-1:0]      mem [MEM_DEPTH];

  logic               valid_c;
  logic               err_c;
  logic [AW-1:0]      word_addr_c;
  logic [AW-1:0]      align_mask_c;
  logic [DW-1:0]      rd_word_c;
  logic [NB-1:0]      be_c;
  logic               unused_ok;

  // HBURST and the SEQ/NONSEQ distinction carry no meaning for this responder.
  assign unused_ok = ^{HBURST, HTRANS[0]};

  // Address-phase decode and legality check.
  always_comb begin
    valid_c      = HSEL & HTRANS[1];
    word_addr_c  = HADDR >> BSH;
    align_mask_c = (AW'(1) << HSIZE) - AW'(1);
    err_c        = (word_addr_c >= AW'(MEM_DEPTH)) ||
                   (HSIZE > 3'(BSH)) ||
                   ((HADDR & align_mask_c) != '0);
  end

  // Byte-lane enables for the latched write.
  always_comb begin
    be_c = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      be_c[b] = (b >= 32'(lane_q)) && (b < 32'(lane_q) + (32'd1 << size_q));
    end
  end

  assign rd_word_c = mem[idx_q];

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    size_d  = size_q;
    write_d = write_q;
    rdata_d = rdata_q;

    if (state_q == S_DATA) begin
      rdata_d = rd_word_c;
    end

    case (state_q)
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ERR1: state_d = S_ERR2;
      S_IDLE, S_DATA, S_ERR2: begin
        state_d = S_IDLE;
        if (valid_c) begin
          idx_d   = HADDR[BSH +: IDX_W];
          lane_d  = HADDR[BSH-1:0];
          size_d  = HSIZE;
          write_d = HWRITE;
          if (err_c) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end else begin
            state_d = S_DATA;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    hready_d = !(state_d inside {S_WAIT, S_ERR1});
    hresp_d  = state_d inside {S_ERR1, S_ERR2};
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      lane_q   <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      lane_q   <= lane_d;
      size_q   <= size_d;
      write_q  <= write_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
      rdata_q  <= rdata_d;
    end
  end

  // Write commits at the edge that ends the DATA cycle; reset aborts it.
  always_ff @(posedge HCLK) begin
    if (!HRESET && (state_q == S_DATA) && write_q) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (be_c[b]) begin
          mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  assign HREADY = hready_q;
  assign HRESP  = hresp_q;
  assign HRDATA = (state_q == S_DATA) ? rd_word_c : rdata_q;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: three instances (WAIT_STATES 1, 0, 3) driven by a
// pipelined AHB master and checked against a byte-array transaction model.
module tb_ahb_mem_slave;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned NDUT  = 3;
  localparam int          LIMIT = 20000;

  typedef struct {
    logic          sel;
    logic [1:0]    trans;
    logic          wr;
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic [DW-1:0] wdata;
  } xfer_t;

  logic          clk = 1'b0;
  logic          hreset [NDUT];
  logic          hsel   [NDUT];
  logic [AW-1:0] haddr  [NDUT];
  logic [1:0]    htrans [NDUT];
  logic          hwrite [NDUT];
  logic [2:0]    hsize  [NDUT];
  logic [2:0]    hburst [NDUT];
  logic [DW-1:0] hwdata [NDUT];
  logic          hready [NDUT];
  logic          hresp  [NDUT];
  logic [DW-1:0] hrdata [NDUT];

  logic [7:0]    mm [NDUT][DEPTH*NB];
  xfer_t         xq [$];
  logic [DW-1:0] rd_log [$];
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ahb_mem_slave #(
      .AHB_DATA_WIDTH   (DW),
      .AHB_ADDRESS_WIDTH(AW),
      .MEM_DEPTH        (DEPTH),
      .WAIT_STATES      (g == 0 ? 1 : (g == 1 ? 0 : 3))
    ) u_dut (
      .HCLK  (clk),
      .HRESET(hreset[g]),
      .HSEL  (hsel[g]),
      .HADDR (haddr[g]),
      .HTRANS(htrans[g]),
      .HWRITE(hwrite[g]),
      .HSIZE (hsize[g]),
      .HBURST(hburst[g]),
      .HWDATA(hwdata[g]),
      .HREADY(hready[g]),
      .HRESP (hresp[g]),
      .HRDATA(hrdata[g])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic xfer_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                               input logic [AW-1:0] a, input logic [2:0] sz,
                               input logic [DW-1:0] wd);
    xfer_t x;
    x.sel = sel; x.trans = tr; x.wr = wr; x.addr = a; x.size = sz; x.wdata = wd;
    return x;
  endfunction

  // Model rules: a beat is illegal if out of range, wider than the bus, or misaligned.
  function automatic logic is_err(input xfer_t x);
    longint unsigned a = longint'(x.addr);
    return (a / NB >= DEPTH) || (x.size > 3) || (a % (64'd1 << x.size) != 0);
  endfunction

  function automatic logic [DW-1:0] rd_word(input int d, input logic [AW-1:0] a);
    logic [DW-1:0] w;
    int base = int'(a / NB) * NB;
    for (int k = 0; k < NB; k++) w[8*k +: 8] = mm[d][base + k];
    return w;
  endfunction

  task automatic commit(input int d, input xfer_t x);
    int lane = int'(x.addr % NB);
    for (int k = 0; k < (1 << x.size); k++) mm[d][int'(x.addr) + k] = x.wdata[8*(lane + k) +: 8];
  endtask

  task automatic drive(input int d, input xfer_t x);
    hsel[d] = x.sel; htrans[d] = x.trans; hwrite[d] = x.wr;
    haddr[d] = x.addr; hsize[d] = x.size; hburst[d] = 3'b001;
  endtask

  // Pipelined master: runs xq on instance d; entered and left at posedge+1.
  task automatic run_seq(input int d);
    xfer_t p, a;
    logic  pv, pe, exp_rdy;
    int    pc, i, guard, ws;
    ws = ws_of(d);
    p = mk(1'b0, 2'b00, 1'b0, '0, 3'd0, '0);
    pv = 1'b0; pe = 1'b0; pc = 0; i = 0; guard = 0;
    rd_log.delete();
    while ((i < xq.size() || pv) && guard < LIMIT) begin
      a = (i < xq.size()) ? xq[i] : mk(1'b1, 2'b00, 1'b0, '0, 3'd0, '0);
      drive(d, a);
      hwdata[d] = p.wdata;
      @(negedge clk);
      exp_rdy = !pv ? 1'b1 : (pe ? (pc == 1) : (pc == ws));
      check($sformatf("d%0d hready", d), 64'(hready[d]), 64'(exp_rdy));
      check($sformatf("d%0d hresp", d), 64'(hresp[d]), 64'(pv & pe));
      if (exp_rdy) begin
        if (pv && !pe) begin
          if (p.wr) commit(d, p);
          else begin
            check($sformatf("d%0d hrdata @%h", d, p.addr), hrdata[d], rd_word(d, p.addr));
            rd_log.push_back(hrdata[d]);
          end
        end
        p  = a;
        pv = a.sel && a.trans[1];
        pe = pv && is_err(a);
        pc = 0;
        if (i < xq.size()) i++;
      end else begin
        pc++;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    check($sformatf("d%0d run_bound", d), 64'(guard >= LIMIT), 64'(0));
    xq.delete();
  endtask

  task automatic push_random(input int n);
    xfer_t x;
    int    r, word, off;
    for (int k = 0; k < n; k++) begin
      r = int'($urandom_range(0, 99));
      x.trans = (r < 10) ? 2'b00 : (r < 20) ? 2'b01 : (r < 60) ? 2'b10 : 2'b11;
      x.sel   = ($urandom_range(0, 9) != 0);
      x.wr    = $urandom_range(0, 1) == 1;
      x.size  = ($urandom_range(0, 9) != 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      if ($urandom_range(0, 9) == 0) word = int'(DEPTH + $urandom_range(0, 20));
      else if ($urandom_range(0, 1) == 1) word = int'($urandom_range(0, 7));
      else word = int'($urandom_range(0, DEPTH - 1));
      off = int'($urandom_range(0, NB - 1));
      if ($urandom_range(0, 3) != 0) off = off & ~((1 << x.size) - 1) & (NB - 1);
      x.addr  = AW'(word * NB + off);
      x.wdata = {$urandom, $urandom};
      xq.push_back(x);
    end
  endtask

  logic [DW-1:0] prior;

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      hreset[d] = 1'b1;
      drive(d, mk(1'b1, 2'b10, 1'b1, 32'h10, 3'd3, '0));
      hwdata[d] = 64'hDEAD_BEEF_DEAD_BEEF;
    end
    // Two reset edges with a NONSEQ write presented on the bus.
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      hreset[d] = 1'b0;
      drive(d, mk(1'b1, 2'b00, 1'b0, '0, 3'd0, '0));
    end
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("d%0d rst hready", d), 64'(hready[d]), 64'(1));
      check($sformatf("d%0d rst hresp", d), 64'(hresp[d]), 64'(0));
      check($sformatf("d%0d rst hrdata", d), hrdata[d], 64'(0));
    end
    @(posedge clk);
    #1;

    // Fill every memory with known data.
    for (int d = 0; d < NDUT; d++) begin
      for (int w = 0; w < DEPTH; w++) xq.push_back(mk(1'b1, 2'b10, 1'b1, AW'(w * NB), 3'd3, {$urandom, $urandom}));
      run_seq(d);
    end

    // Reset with a pending NONSEQ write must not touch memory.
    hreset[0] = 1'b1;
    drive(0, mk(1'b1, 2'b10, 1'b1, 32'h10, 3'd3, '0));
    hwdata[0] = 64'hBAD0_BAD0_BAD0_BAD0;
    repeat (2) @(posedge clk);
    #1;
    hreset[0] = 1'b0;
    xq.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10, 3'd3, '0));
    run_seq(0);

    // Write / read and byte lanes on the WAIT_STATES=1 instance.
    xq.push_back(mk(1'b1, 2'b10, 1'b1, 32'h10, 3'd3, 64'h1122334455667788));
    xq.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10, 3'd3, '0));
    run_seq(0);
    check("wr_rd 0x10", rd_log[0], 64'h1122334455667788);
    xq.push_back(mk(1'b1, 2'b10, 1'b1, 32'h13, 3'd0, 64'h00000000AA000000));
    xq.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10, 3'd3, '0));
    run_seq(0);
    check("byte lane 0x13", rd_log[0], 64'h11223344AA667788);

    // Out-of-range read and misaligned write: ERROR, memory unchanged.
    xq.push_back(mk(1'b1, 2'b10, 1'b0, 32'h800, 3'd3, '0));
    xq.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0, 3'd0, '0));
    xq.push_back(mk(1'b1, 2'b10, 1'b1, 32'h11, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF));
    xq.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10, 3'd3, '0));
    run_seq(0);
    check("err no write", rd_log[0], 64'h11223344AA667788);

    // INCR4 with a BUSY beat on the zero-wait instance, then read back.
    xq.push_back(mk(1'b1, 2'b10, 1'b1, 32'h20, 3'd3, 64'd1));
    xq.push_back(mk(1'b1, 2'b11, 1'b1, 32'h28, 3'd3, 64'd2));
    xq.push_back(mk(1'b1, 2'b01, 1'b1, 32'h30, 3'd3, 64'd99));
    xq.push_back(mk(1'b1, 2'b11, 1'b1, 32'h30, 3'd3, 64'd3));
    xq.push_back(mk(1'b1, 2'b11, 1'b1, 32'h38, 3'd3, 64'd4));
    for (int k = 0; k < 4; k++) xq.push_back(mk(1'b1, (k == 0) ? 2'b10 : 2'b11, 1'b0, AW'(32'h20 + 8 * k), 3'd3, '0));
    run_seq(1);
    for (int k = 0; k < 4; k++) check($sformatf("burst rd %0d", k), rd_log[k], 64'(k + 1));

    // Randomized traffic on every instance.
    for (int d = 0; d < NDUT; d++) begin
      push_random(300);
      run_seq(d);
    end

    // Reset during the WAIT state of a write aborts it.
    prior = rd_word(2, 32'h40);
    drive(2, mk(1'b1, 2'b10, 1'b1, 32'h40, 3'd3, '0));
    @(posedge clk);
    #1;
    hreset[2] = 1'b1;
    drive(2, mk(1'b1, 2'b00, 1'b0, '0, 3'd0, '0));
    hwdata[2] = ~prior;
    @(negedge clk);
    check("midrst wait hready", 64'(hready[2]), 64'(0));
    @(posedge clk);
    #1;
    hreset[2] = 1'b0;
    @(negedge clk);
    check("midrst hready", 64'(hready[2]), 64'(1));
    check("midrst hresp", 64'(hresp[2]), 64'(0));
    check("midrst hrdata", hrdata[2], 64'(0));
    @(posedge clk);
    #1;
    xq.push_back(mk(1'b1, 2'b10, 1'b0, 32'h40, 3'd3, '0));
    run_seq(2);
    check("midrst prior data", rd_log[0], prior);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
